sram_arbiter: RTL and testbench

- Single-port controller for the external 512K x 8 async SRAM.
- Shares the SRAM between two requesters:
  - the display read port, which fetches pixels for the VGA picture generator;
  - the write port, used by the bitmap/palette loader or the MCU.
- Owns the SRAM pins (address, data tristate, cs/we/oe) and sequences all read/write bus cycles.
- Requesters never drive the SRAM directly.

---
 rtl/sram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Arbiter and bus sequencer for a 512K x 8 async SRAM shared by a display read port and a write port.
// Optional macro ARB_STARVE_GUARD_EN: force a pending write after STARVE_LIMIT consecutive display grants.
module sram_arbiter #(
  parameter int READ_WAIT    = 1,
  parameter int WE_CYCLES    = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        char_clock,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [18:0] disp_addr,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        wr_req,
  input  logic [18:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  inout  wire  [7:0]  data,
  output logic [18:0] adress,
  output logic        cs,
  output logic        we,
  output logic        oe,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic        drive_q, drive_d, busy_q, busy_d;
  logic [18:0] adress_q, adress_d;
  logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic        valid_q, valid_d, ack_q, ack_d;
  logic        grant_rd, grant_wr, rd_done, force_wr;

`ifdef ARB_STARVE_GUARD_EN
  logic [4:0] starve_q, starve_d;

  assign force_wr = wr_req && (starve_q >= 5'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!wr_req || grant_wr) starve_d = 5'd0;
      else if (grant_rd)       starve_d = starve_q + 5'd1;
    end
  end

  always_ff @(posedge char_clock or posedge reset) begin
    if (reset) starve_q <= 5'd0;
    else       starve_q <= starve_d;
  end
`else
  assign force_wr = 1'b0;
`endif

  assign grant_rd = (state_q == S_IDLE) && disp_req && !force_wr;
  assign grant_wr = (state_q == S_IDLE) && wr_req && (!disp_req || force_wr);
  assign rd_done  = (state_q == S_RD_WAIT) && (wait_q == 4'd0);

  // State register
  always_ff @(posedge char_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; wait_q counts down the remaining cycles of RD_WAIT / WR_PULSE
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (grant_rd) begin
          state_d = S_RD_WAIT;
          wait_d  = 4'(READ_WAIT - 1);
        end else if (grant_wr) begin
          state_d = S_WR_SETUP;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == 4'd0) state_d = S_IDLE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        wait_d  = 4'(WE_CYCLES - 1);
      end
      S_WR_PULSE: begin
        if (wait_q == 4'd0) state_d = S_WR_HOLD;
        else                wait_d  = wait_q - 4'd1;
      end
      S_WR_HOLD: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so every SRAM pin comes straight from a flop
  always_comb begin
    cs_d     = (state_d == S_IDLE);
    oe_d     = (state_d != S_RD_WAIT);
    we_d     = (state_d != S_WR_PULSE);
    drive_d  = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
    busy_d   = (state_d != S_IDLE);
    adress_d = adress_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (grant_rd) begin
      adress_d = disp_addr;
    end else if (grant_wr) begin
      adress_d = wr_addr;
      wdata_d  = wr_data;
    end
    if (rd_done) rdata_d = data;
    valid_d = rd_done;
    ack_d   = (state_q == S_WR_HOLD);
  end

  always_ff @(posedge char_clock or posedge reset) begin
    if (reset) begin
      cs_q     <= 1'b1;
      we_q     <= 1'b1;
      oe_q     <= 1'b1;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
      adress_q <= 19'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      cs_q     <= cs_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      drive_q  <= drive_d;
      busy_q   <= busy_d;
      adress_q <= adress_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
    end
  end

  assign data       = drive_q ? wdata_q : 8'hzz;
  assign adress     = adress_q;
  assign cs         = cs_q;
  assign we         = we_q;
  assign oe         = oe_q;
  assign busy       = busy_q;
  assign disp_data  = rdata_q;
  assign disp_valid = valid_q;
  assign wr_ack     = ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural async SRAM model, table-driven transfers,
// plus hand-written sequences for contention, reset mid-write, starvation and back-to-back reads.
module tb_sram_arbiter;

  localparam int RW = 1;
  localparam int WC = 2;
  localparam int SL = 16;

  logic        char_clock;
  logic        reset;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  wire  [7:0]  data;
  logic [18:0] adress;
  logic        cs, we, oe, busy;

  sram_arbiter #(.READ_WAIT(RW), .WE_CYCLES(WC), .STARVE_LIMIT(SL)) dut (
    .char_clock (char_clock),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .data       (data),
    .adress     (adress),
    .cs         (cs),
    .we         (we),
    .oe         (oe),
    .busy       (busy)
  );

  initial char_clock = 1'b0;
  always #5 char_clock = ~char_clock;

  // Async SRAM model: drives the bus while selected with oe low, writes on the rising edge of we
  logic [7:0] mem [0:524287];
  bit         model_en = 1'b0;

  assign data = (!cs && !oe) ? mem[adress] : 8'hzz;

  always @(posedge we) begin
    if (model_en && !reset && !cs) mem[adress] = data;
  end

  int overlap_err = 0;
  int gap_err     = 0;
  bit prev_wr     = 1'b0;

  always @(negedge char_clock) begin
    if (!oe && !we) overlap_err++;
    if (!oe && prev_wr) gap_err++;
    prev_wr = !cs && oe;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
  endfunction

  // Both tasks start and end on a negative clock edge
  task automatic do_read(input logic [18:0] a, input logic [7:0] exp, input string tag);
    int n;
    int oe_low;
    bit seen;
    logic [7:0] got;
    disp_req = 1'b1;
    disp_addr = a;
    n = 0; oe_low = 0; seen = 1'b0; got = 8'h00;
    while (!seen && n < 20) begin
      @(negedge char_clock);
      n++;
      if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (!oe) begin
        oe_low++;
        check({tag, "_addr"}, 32'(adress), 32'(a));
      end
      if (disp_valid) begin
        seen = 1'b1;
        got = disp_data;
      end
    end
    disp_req = 1'b0;
    $display("read  addr=0x%05h data=0x%02h cycles=%0d", a, got, n);
    check({tag, "_latency"}, 32'(n), 32'(RW + 1));
    check({tag, "_oe_cycles"}, 32'(oe_low), 32'(RW));
    check({tag, "_data"}, 32'(got), 32'(exp));
  endtask

  task automatic do_write(input logic [18:0] a, input logic [7:0] d, input string tag);
    int n;
    int we_low;
    int cs_low;
    int bus_bad;
    bit seen;
    wr_req = 1'b1;
    wr_addr = a;
    wr_data = d;
    n = 0; we_low = 0; cs_low = 0; bus_bad = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge char_clock);
      n++;
      if (!cs) cs_low++;
      if (!we) begin
        we_low++;
        if (data !== d || adress !== a) bus_bad++;
      end
      if (wr_ack) seen = 1'b1;
    end
    wr_req = 1'b0;
    $display("write addr=0x%05h data=0x%02h cycles=%0d", a, d, n);
    check({tag, "_ack_latency"}, 32'(n), 32'(WC + 3));
    check({tag, "_we_low"}, 32'(we_low), 32'(WC));
    check({tag, "_cs_low"}, 32'(cs_low), 32'(WC + 2));
    check({tag, "_bus_stable"}, 32'(bus_bad), 32'd0);
    check({tag, "_mem"}, 32'(mem[a]), 32'(d));
  endtask

  typedef struct {
    bit          is_wr;
    logic [18:0] addr;
    logic [7:0]  wdat;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n, k, last, vcyc, acyc, nreads, acks;
    logic [7:0] sim_rd;

    vecs[0] = '{1'b0, 19'h12345, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 19'h00200, 8'h3C, 8'h00};
    vecs[2] = '{1'b0, 19'h00200, 8'h00, 8'h3C};
    vecs[3] = '{1'b1, 19'h7FFFF, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 19'h7FFFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b1, 19'h40000, 8'h81, 8'h00};
    vecs[6] = '{1'b1, 19'h40001, 8'h18, 8'h00};
    vecs[7] = '{1'b0, 19'h40000, 8'h00, 8'h81};
    vecs[8] = '{1'b0, 19'h40001, 8'h00, 8'h18};

    reset = 1'b1;
    disp_req = 1'b0; disp_addr = 19'd0;
    wr_req = 1'b0; wr_addr = 19'd0; wr_data = 8'd0;
    for (int i = 0; i < 524288; i++) mem[i] = pat(19'(i));
    mem[19'h12345] = 8'hA5;

    @(negedge char_clock);
    @(negedge char_clock);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_we", 32'(we), 32'd1);
    check("rst_oe", 32'(oe), 32'd1);
    check("rst_adress", 32'(adress), 32'd0);
    check("rst_disp_data", 32'(disp_data), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    model_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].wdat, $sformatf("v%0d", i));
      else               do_read(vecs[i].addr, vecs[i].exp, $sformatf("v%0d", i));
    end

    // Request dropped and inputs changed right after grant: the captured write must complete
    wr_req = 1'b1; wr_addr = 19'h00400; wr_data = 8'h5E;
    @(negedge char_clock);
    wr_req = 1'b0; wr_addr = 19'h00401; wr_data = 8'hE5;
    n = 1; acks = 0;
    while (acks == 0 && n < 20) begin
      @(negedge char_clock);
      n++;
      if (wr_ack) acks++;
    end
    $display("drop  addr=0x00400 ack_cycle=%0d", n);
    check("drop_ack_latency", 32'(n), 32'(WC + 3));
    check("drop_mem_400", 32'(mem[19'h00400]), 32'h5E);
    check("drop_mem_401", 32'(mem[19'h00401]), 32'(pat(19'h00401)));

    // Simultaneous requests: read first, then the write
    disp_req = 1'b1; disp_addr = 19'h12345;
    wr_req = 1'b1; wr_addr = 19'h00500; wr_data = 8'h6B;
    n = 0; vcyc = 0; acyc = 0; sim_rd = 8'h00;
    while (acyc == 0 && n < 40) begin
      @(negedge char_clock);
      n++;
      if (disp_valid) begin vcyc = n; sim_rd = disp_data; disp_req = 1'b0; end
      if (wr_ack) begin acyc = n; wr_req = 1'b0; end
    end
    $display("both  read_cycle=%0d write_cycle=%0d", vcyc, acyc);
    check("both_rd_cycle", 32'(vcyc), 32'(RW + 1));
    check("both_rd_data", 32'(sim_rd), 32'hA5);
    check("both_wr_cycle", 32'(acyc), 32'(RW + 1 + WC + 3));
    check("both_mem", 32'(mem[19'h00500]), 32'h6B);

    // Reset asserted mid write pulse
    wr_req = 1'b1; wr_addr = 19'h00300; wr_data = 8'h77;
    n = 0;
    while (we && n < 10) begin
      @(negedge char_clock);
      n++;
    end
    check("rstw_pulse_entered", 32'(we), 32'd0);
    #1 reset = 1'b1;
    #1;
    $display("reset asserted during write pulse");
    check("rstw_we", 32'(we), 32'd1);
    check("rstw_cs", 32'(cs), 32'd1);
    check("rstw_oe", 32'(oe), 32'd1);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_ack", 32'(wr_ack), 32'd0);
    wr_req = 1'b0;
    @(negedge char_clock);
    @(negedge char_clock);
    reset = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge char_clock);
      if (wr_ack) acks++;
    end
    check("rstw_no_ack", 32'(acks), 32'd0);
    check("rstw_idle_after", 32'(busy), 32'd0);
    check("rstw_mem_untouched", 32'(mem[19'h00300]), 32'(pat(19'h00300)));
    do_read(19'h12345, 8'hA5, "post_rst");

    // Continuous display traffic with a write pending
    disp_req = 1'b1; disp_addr = 19'h01000;
    wr_req = 1'b1; wr_addr = 19'h00600; wr_data = 8'h99;
    n = 0; nreads = 0; acks = 0;
`ifdef ARB_STARVE_GUARD_EN
    while (acks == 0 && n < 400) begin
      @(negedge char_clock);
      n++;
      if (wr_ack) acks++;
      else if (disp_valid) nreads++;
    end
    disp_req = 1'b0; wr_req = 1'b0;
    $display("starve reads_before_write=%0d acks=%0d", nreads, acks);
    check("starve_reads", 32'(nreads), 32'(SL));
    check("starve_acked", 32'(acks), 32'd1);
    check("starve_mem", 32'(mem[19'h00600]), 32'h99);
`else
    while (nreads < 100 && n < 400) begin
      @(negedge char_clock);
      n++;
      if (wr_ack) acks++;
      if (disp_valid) nreads++;
    end
    disp_req = 1'b0; wr_req = 1'b0;
    $display("starve reads=%0d acks=%0d", nreads, acks);
    check("starve_reads", 32'(nreads), 32'd100);
    check("starve_no_ack", 32'(acks), 32'd0);
`endif

    // Back-to-back reads over addresses 0..511
    disp_req = 1'b1; disp_addr = 19'd0;
    k = 0; n = 0; last = 0;
    while (k < 512 && n < 2000) begin
      @(negedge char_clock);
      n++;
      if (disp_valid) begin
        $display("b2b   addr=0x%05h data=0x%02h cycle=%0d", k, disp_data, n);
        check($sformatf("b2b_data_%0d", k), 32'(disp_data), 32'(mem[19'(k)]));
        if (k > 0) check($sformatf("b2b_spacing_%0d", k), 32'(n - last), 32'(RW + 1));
        last = n;
        k++;
        disp_addr = 19'(k);
      end
    end
    disp_req = 1'b0;
    check("b2b_count", 32'(k), 32'd512);

    @(negedge char_clock);
    check("no_oe_we_overlap", 32'(overlap_err), 32'd0);
    check("idle_gap_write_read", 32'(gap_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
